demux_1to16_seq: RTL

DEMUX_1TO16_SEQ -- requirements
Module: demux_1to16_seq

---
 rtl/demux_1to16_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/demux_1to16_seq.sv
// demux_1to16_seq: 1-to-16 serial demultiplexer with an addressed mode and a
// scan mode. In addressed mode (mode=0), each qualified bit goes to lane sel.
// In scan mode (mode=1), an internal pointer walks lanes 0..15 and builds
// complete words, with no gap cycle between words.
// Optional feature: define DEMUX_PARITY_EN to add the word_parity output.
module demux_1to16_seq #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  input  logic [3:0]  sel,
  input  logic        mode,
  output logic [15:0] dout,
  output logic [15:0] lane_strobe,
  output logic        word_valid
`ifdef DEMUX_PARITY_EN
  ,
  output logic        word_parity
`endif
);

  // state | meaning
  // ADDR  | mode_q=0, bits routed to lane sel, ptr holds
  // SCAN  | mode_q=1, bits routed to lane ptr, ptr auto-increments
  typedef enum logic {
    ADDR = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        mode_q;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  ptr_eff;
  logic [3:0]  lane;
  logic [15:0] dout_q, dout_d;
  logic [15:0] strobe_q, strobe_d;
  logic        wv_q, wv_d;

  // The state register is the registered copy of mode.
  assign mode_q = (state_q == SCAN);

  // Next-state logic. A mode change clears the pointer in the same cycle, so
  // a bit arriving on the change cycle is handled under the new mode, and in
  // scan mode that bit lands in lane 0.
  always_comb begin
    state_d  = mode ? SCAN : ADDR;
    ptr_eff  = (mode != mode_q) ? 4'd0 : ptr_q;
    lane     = mode ? ptr_eff : sel;
    ptr_d    = ptr_eff;
    dout_d   = dout_q;
    strobe_d = 16'h0000;
    wv_d     = 1'b0;
    if (din_valid) begin
      dout_d[lane] = din;
      strobe_d     = 16'h0001 << lane;
      if (mode) begin
        ptr_d = ptr_eff + 4'd1;
        wv_d  = (ptr_eff == 4'd15);
      end
    end
  end

  // State, pointer and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ADDR;
      ptr_q    <= 4'd0;
      dout_q   <= RESET_VAL;
      strobe_q <= 16'h0000;
      wv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      wv_q     <= wv_d;
    end
  end

  assign dout        = dout_q;
  assign lane_strobe = strobe_q;
  assign word_valid  = wv_q;

`ifdef DEMUX_PARITY_EN
  logic parity_q, parity_d;

  // Even parity of the finished word, forced to 0 outside the word_valid cycle.
  always_comb begin
    parity_d = wv_d & (^dout_d);
  end

  // Parity register, aligned with word_valid.
  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end

  assign word_parity = parity_q;
`endif

endmodule
